// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: transition-minimised, DC-balanced video words and fixed control tokens.
// Latency: 2 pixel_clk cycles, registered in two stages. tmds_data is driven directly from a flop.
// Backpressure: none. The encoder accepts one input and emits one word on every pixel_clk.
//
// Ports:
//   pixel_clk  - pixel clock; all state updates on the rising edge
//   rst_n      - asynchronous active-low reset (release synchronised externally)
//   de         - data enable: 1 = video period, 0 = blanking/control period
//   data[7:0]  - pixel component, used only when de=1
//   ctrl[1:0]  - {C1,C0} control bits, used only when de=0
//   tmds_data  - 10-bit encoded word, bit 0 transmitted first
module tmds_encoder (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds_data
);

  localparam logic [9:0] TOK_00 = 10'h354;
  localparam logic [9:0] TOK_01 = 10'h0AB;
  localparam logic [9:0] TOK_10 = 10'h154;
  localparam logic [9:0] TOK_11 = 10'h2AB;

  // ---------------------------------------------------------------
  // Stage 1: transition minimisation
  // ---------------------------------------------------------------
  logic [3:0] w_n1_d;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n1_d = w_n1_d + {3'b000, data[i]};
    end
  end

  // XNOR chaining is picked when it yields fewer transitions. The tie at
  // four ones is broken on D[0] so that encoding stays deterministic.
  assign w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !data[0]);

  always_comb begin
    w_qm    = 9'd0;
    w_qm[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ data[i]) : (w_qm[i-1] ^ data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  logic       r_de;
  logic [1:0] r_ctrl;
  logic [8:0] r_qm;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
      r_qm   <= 9'd0;
    end else begin
      r_de   <= de;
      r_ctrl <= ctrl;
      r_qm   <= w_qm;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: DC balancing and the control token mux
  // ---------------------------------------------------------------
  logic [3:0]        w_n1_q;
  logic signed [5:0] w_bal;       // n1 - n0 of q_m[7:0], range -8..+8
  logic signed [5:0] w_cnt_ext;
  logic signed [5:0] w_cnt_nxt;
  logic [9:0]        w_word;
  logic              w_cnt_zero;
  logic              w_cnt_pos;
  logic              w_cnt_neg;
  logic signed [4:0] r_cnt;       // running disparity; bounded to +/-10, never wraps
  logic [9:0]        r_tmds_data;

  always_comb begin
    w_n1_q = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_n1_q = w_n1_q + {3'b000, r_qm[i]};
    end
  end

  // n1 - n0 = 2*n1 - 8. Six bits are used so that 2*n1 = 16 does not wrap.
  assign w_bal      = $signed({1'b0, w_n1_q, 1'b0}) - 6'sd8;
  assign w_cnt_ext  = {r_cnt[4], r_cnt};
  assign w_cnt_zero = (r_cnt == 5'sd0);
  assign w_cnt_neg  = r_cnt[4];
  assign w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;

  always_comb begin
    w_word    = TOK_00;
    w_cnt_nxt = 6'sd0;
    if (!r_de) begin
      // Blanking resets the disparity, so the next video word starts balanced.
      case (r_ctrl)
        2'b00:   w_word = TOK_00;
        2'b01:   w_word = TOK_01;
        2'b10:   w_word = TOK_10;
        default: w_word = TOK_11;
      endcase
      w_cnt_nxt = 6'sd0;
    end else if (w_cnt_zero || (w_bal == 6'sd0)) begin
      w_word    = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
      w_cnt_nxt = w_cnt_ext + (r_qm[8] ? w_bal : -w_bal);
    end else if ((w_cnt_pos && (w_bal > 6'sd0)) || (w_cnt_neg && (w_bal < 6'sd0))) begin
      // Disparity would grow further, so send the inverted byte.
      w_word    = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt = w_cnt_ext + (r_qm[8] ? 6'sd2 : 6'sd0) - w_bal;
    end else begin
      w_word    = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt = w_cnt_ext + w_bal - (r_qm[8] ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 5'sd0;
      r_tmds_data <= TOK_00;
    end else begin
      r_cnt       <= w_cnt_nxt[4:0];
      r_tmds_data <= w_word;
    end
  end

  assign tmds_data = r_tmds_data;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vectors with hand-derived words, then a random stream checked against a reference encoder.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at that same point, after the next edge.
// The DUT has no handshake, so the stream never stalls.
module tb_tmds_encoder;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [9:0] tmds_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pixel_clk = ~pixel_clk;

  tmds_encoder dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .de        (de),
    .data      (data),
    .ctrl      (ctrl),
    .tmds_data (tmds_data)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present one input word and let one rising edge sample it. Afterwards
  // tmds_data shows the word that was presented one call earlier.
  task automatic send(input logic d_e, input logic [7:0] d, input logic [1:0] c);
    de   = d_e;
    data = d;
    ctrl = c;
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic int cnt_now();
    return int'(dut.r_cnt);
  endfunction

  // Reference encoder. It uses plain integer arithmetic on the disparity.
  function automatic logic [9:0] ref_enc(input logic v, input logic [7:0] d,
                                         input logic [1:0] c, inout int cnt);
    logic [8:0] q;
    int         n1d, n1, n0;
    logic       xn;
    if (!v) begin
      cnt = 0;
      case (c)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1d  = $countones(d);
    xn   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1   = $countones(q[7:0]);
    n0   = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      if (q[8]) begin
        cnt = cnt + n1 - n0;
        return {1'b0, 1'b1, q[7:0]};
      end
      cnt = cnt + n0 - n1;
      return {1'b1, 1'b0, ~q[7:0]};
    end
    if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      cnt = cnt + (q[8] ? 2 : 0) + n0 - n1;
      return {1'b1, q[8], ~q[7:0]};
    end
    cnt = cnt + n1 - n0 - (q[8] ? 0 : 2);
    return {1'b0, q[8], q[7:0]};
  endfunction

  // Receiver-side decode of a video word back to the pixel byte.
  function automatic logic [7:0] dec(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  logic [9:0] tok_exp [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] xor_exp [3] = '{10'h100, 10'h3FF, 10'h100};
  int         xor_cnt [3] = '{-8, 2, -6};
  // Words seen through v00, v00, v00, ctrl=01, v00, blank (starting from blanking).
  logic [9:0] clr_exp [6] = '{10'h354, 10'h100, 10'h3FF, 10'h100, 10'h0AB, 10'h100};
  int         clr_cnt [6] = '{0, -8, 2, -6, 0, -8};

  initial begin
    logic       p_de;
    logic [7:0] p_data;
    logic [1:0] p_ctrl;
    logic       n_de;
    logic [7:0] n_data;
    logic [1:0] n_ctrl;
    logic [9:0] exp_w;
    int         mcnt;
    int         c_abs;

    rst_n = 1'b0;
    de    = 1'b0;
    data  = 8'h00;
    ctrl  = 2'b00;

    // Reset held low while the inputs toggle at random.
    #2;
    for (int i = 0; i < 4; i++) begin
      de   = 1'($urandom_range(0, 1));
      data = 8'($urandom_range(0, 255));
      ctrl = 2'($urandom_range(0, 3));
      @(posedge pixel_clk);
      #1;
    end
    check("rst_hold_out", int'(tmds_data), int'(10'h354));
    check("rst_hold_cnt", cnt_now(), 0);
    rst_n = 1'b1;

    // Control tokens, stepped through in order.
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 8'h00, (i < 4) ? 2'(i) : 2'b00);
      if (i >= 1) check("ctrl_tok", int'(tmds_data), int'(tok_exp[i-1]));
    end

    // XOR path: 8'h00 repeated, starting from a blanking word.
    send(1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'h00, 2'b00);
      if (i >= 1) begin
        check("xor_word", int'(tmds_data), int'(xor_exp[i-1]));
        check("xor_cnt", cnt_now(), xor_cnt[i-1]);
      end
    end

    // XNOR path: 8'hFF as the first video word after blanking.
    send(1'b0, 8'h00, 2'b00);
    send(1'b1, 8'hFF, 2'b00);
    send(1'b0, 8'h00, 2'b00);
    check("xnor_word", int'(tmds_data), int'(10'h200));
    check("xnor_cnt", cnt_now(), -8);

    // A single control word clears the disparity between two video bursts.
    for (int i = 0; i < 6; i++) begin
      case (i)
        3:       send(1'b0, 8'h00, 2'b01);
        5:       send(1'b0, 8'h00, 2'b00);
        default: send(1'b1, 8'h00, 2'b00);
      endcase
      check("clr_word", int'(tmds_data), int'(clr_exp[i]));
      check("clr_cnt", cnt_now(), clr_cnt[i]);
    end

    // Reset asserted mid-video takes effect without a clock edge.
    send(1'b1, 8'h00, 2'b00);
    send(1'b1, 8'h00, 2'b00);
    send(1'b1, 8'h00, 2'b00);
    check("pre_rst_word", int'(tmds_data), int'(10'h3FF));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(tmds_data), int'(10'h354));
    check("async_rst_cnt", cnt_now(), 0);
    #2;
    rst_n = 1'b1;
    send(1'b1, 8'h00, 2'b00);
    check("post_rst_first", int'(tmds_data), int'(10'h354));
    send(1'b1, 8'h00, 2'b00);
    check("post_rst_video", int'(tmds_data), int'(10'h100));
    check("post_rst_cnt", cnt_now(), -8);

    // Random stream compared cycle by cycle against the reference encoder.
    send(1'b0, 8'h00, 2'b00);
    send(1'b0, 8'h00, 2'b00);
    p_de   = 1'b0;
    p_data = 8'h00;
    p_ctrl = 2'b00;
    mcnt   = 0;
    for (int i = 0; i < 20000; i++) begin
      n_de   = ($urandom_range(0, 7) != 0);
      n_data = 8'($urandom_range(0, 255));
      n_ctrl = 2'($urandom_range(0, 3));
      send(n_de, n_data, n_ctrl);
      exp_w = ref_enc(p_de, p_data, p_ctrl, mcnt);
      check("rand_word", int'(tmds_data), int'(exp_w));
      check("rand_cnt", cnt_now(), mcnt);
      c_abs = (cnt_now() < 0) ? -cnt_now() : cnt_now();
      check("cnt_bound", int'(c_abs <= 10), 1);
      if (p_de) check("decode", int'(dec(tmds_data)), int'(p_data));
      p_de   = n_de;
      p_data = n_data;
      p_ctrl = n_ctrl;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
